// File: rtl/vpu_mem_responder.sv
// vpu_mem_responder
// Memory-side responder for the VPU operand/result interface. A DEPTH-word
// flop array serves two read ports (A, B) with a fixed RD_LAT-cycle latency,
// one write port (C) and a host preload port. After reset the array is swept
// to zero before any request is accepted.
module vpu_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              req_c,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] data_c,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              mem_rdy,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic              err_oob
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    // Full-width range check; extra MSB keeps DEPTH == 2**ADDR_W representable.
    function automatic logic f_oob(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DEPTH_EXT);
    endfunction

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_vld_a;
    logic [RD_LAT-1:0] r_vld_b;
    logic [DATA_W-1:0] r_pd_a [RD_LAT];
    logic [DATA_W-1:0] r_pd_b [RD_LAT];
    logic              r_wen;
    logic              r_err_oob;

    logic              w_ready;
    logic              w_oob_a, w_oob_b, w_oob_c, w_oob_h;
    logic [IDX_W-1:0]  w_idx_a, w_idx_b, w_idx_c, w_idx_h;
    logic              w_acc_a, w_acc_b;
    logic              w_wr_c, w_wr_h;
    logic              w_any_oob;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;

    assign w_ready = (r_state == ST_READY);

    assign w_oob_a = f_oob(addr_a);
    assign w_oob_b = f_oob(addr_b);
    assign w_oob_c = f_oob(addr_c);
    assign w_oob_h = f_oob(host_addr);

    assign w_idx_a = addr_a[IDX_W-1:0];
    assign w_idx_b = addr_b[IDX_W-1:0];
    assign w_idx_c = addr_c[IDX_W-1:0];
    assign w_idx_h = host_addr[IDX_W-1:0];

    // Requests only count once the clear sweep is finished.
    assign w_acc_a = w_ready && req_a;
    assign w_acc_b = w_ready && req_b;
    assign w_wr_c  = w_ready && req_c && !w_oob_c;
    // Port C has priority when both writers target the same word.
    assign w_wr_h  = w_ready && host_we && !w_oob_h && !(w_wr_c && (w_idx_h == w_idx_c));

    assign w_any_oob = (req_a && w_oob_a) || (req_b && w_oob_b) ||
                       (req_c && w_oob_c) || (host_we && w_oob_h);

    // Out-of-range reads still travel the pipe but carry zero.
    assign w_rd_a = w_oob_a ? {DATA_W{1'b0}} : r_mem[w_idx_a];
    assign w_rd_b = w_oob_b ? {DATA_W{1'b0}} : r_mem[w_idx_b];

    // Control FSM: a DEPTH-cycle clear sweep, then serve requests until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= {IDX_W{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + IDX_W'(1);
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ST_READY;
                    end else begin
                        r_state <= ST_INIT;
                    end
                end
                ST_READY: begin
                    r_state   <= ST_READY;
                    r_clr_cnt <= r_clr_cnt;
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_clr_cnt <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Storage array: zeroed word by word during INIT, written by host and port C afterwards.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= {DATA_W{1'b0}};
        end else begin
            if (w_wr_h) begin
                r_mem[w_idx_h] <= host_wdata;
            end
            if (w_wr_c) begin
                r_mem[w_idx_c] <= data_c;
            end
        end
    end

    // Read valid shift registers, one stage per cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_a <= {RD_LAT{1'b0}};
            r_vld_b <= {RD_LAT{1'b0}};
        end else begin
            r_vld_a <= (r_vld_a << 1) | RD_LAT'(w_acc_a);
            r_vld_b <= (r_vld_b << 1) | RD_LAT'(w_acc_b);
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Single-stage read data: the stage is the held output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pd_a[0] <= {DATA_W{1'b0}};
                    r_pd_b[0] <= {DATA_W{1'b0}};
                end else begin
                    r_pd_a[0] <= w_acc_a ? w_rd_a : r_pd_a[0];
                    r_pd_b[0] <= w_acc_b ? w_rd_b : r_pd_b[0];
                end
            end
        end else begin : g_latn
            // Multi-stage read data pipe; the last stage only loads on a completion so it holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        r_pd_a[i] <= {DATA_W{1'b0}};
                        r_pd_b[i] <= {DATA_W{1'b0}};
                    end
                end else begin
                    r_pd_a[0] <= w_acc_a ? w_rd_a : r_pd_a[0];
                    r_pd_b[0] <= w_acc_b ? w_rd_b : r_pd_b[0];
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_pd_a[i] <= r_pd_a[i-1];
                        r_pd_b[i] <= r_pd_b[i-1];
                    end
                    r_pd_a[RD_LAT-1] <= r_vld_a[RD_LAT-2] ? r_pd_a[RD_LAT-2] : r_pd_a[RD_LAT-1];
                    r_pd_b[RD_LAT-1] <= r_vld_b[RD_LAT-2] ? r_pd_b[RD_LAT-2] : r_pd_b[RD_LAT-1];
                end
            end
        end
    endgenerate

    // Write acknowledge pulse and sticky out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen     <= 1'b0;
            r_err_oob <= 1'b0;
        end else begin
            r_wen     <= w_wr_c;
            r_err_oob <= r_err_oob || (w_ready && w_any_oob);
        end
    end

    assign data_a       = r_pd_a[RD_LAT-1];
    assign data_b       = r_pd_b[RD_LAT-1];
    assign mem_read_en  = r_vld_a[RD_LAT-1] || r_vld_b[RD_LAT-1];
    assign mem_write_en = r_wen;
    assign err_oob      = r_err_oob;
    assign mem_rdy      = w_ready && (r_vld_a == {RD_LAT{1'b0}}) &&
                          (r_vld_b == {RD_LAT{1'b0}}) && !r_wen;

endmodule

// File: tb/tb_vpu_mem_responder.sv
// Self-checking bench for vpu_mem_responder (DEPTH=32, RD_LAT=2).
// Expected read data is pushed to a queue from a memory model when a request
// is driven and popped when mem_read_en is observed.
module tb_vpu_mem_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 32;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_a, req_b, req_c, host_we;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c, host_addr;
    logic [DATA_W-1:0] data_c, host_wdata;
    logic [DATA_W-1:0] data_a, data_b;
    logic              mem_rdy, mem_read_en, mem_write_en, err_oob;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic              va;
        logic              vb;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] held_a, held_b;

    always #5 clk = ~clk;

    vpu_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a),
        .req_b(req_b), .addr_b(addr_b),
        .req_c(req_c), .addr_c(addr_c), .data_c(data_c),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .data_a(data_a), .data_b(data_b),
        .mem_rdy(mem_rdy), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .err_oob(err_oob)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        sb.delete();
        held_a = '0;
        held_b = '0;
    endtask

    // Drive one cycle of requests, record expectations, update the model.
    task automatic issue(input logic ra, input int aa, input logic rb, input int ab,
                         input logic rc, input int ac, input logic [DATA_W-1:0] dc,
                         input logic hw, input int ha, input logic [DATA_W-1:0] hd);
        exp_t e;
        req_a = ra; addr_a = ADDR_W'(aa);
        req_b = rb; addr_b = ADDR_W'(ab);
        req_c = rc; addr_c = ADDR_W'(ac); data_c = dc;
        host_we = hw; host_addr = ADDR_W'(ha); host_wdata = hd;
        if (ra || rb) begin
            e.va = ra;
            e.vb = rb;
            e.da = (aa < DEPTH) ? model[aa] : '0;
            e.db = (ab < DEPTH) ? model[ab] : '0;
            sb.push_back(e);
        end
        if (hw && ha < DEPTH) model[ha] = hd;
        if (rc && ac < DEPTH) model[ac] = dc;
        step();
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; host_we = 1'b0;
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.va) held_a = e.da;
            if (e.vb) held_b = e.db;
        end
    endtask

    task automatic test_reset();
        int n;
        logic seen_rd;
        rst_n = 1'b0;
        req_a = 0; req_b = 0; req_c = 0; host_we = 0;
        addr_a = '0; addr_b = '0; addr_c = '0; host_addr = '0;
        data_c = '0; host_wdata = '0;
        clear_model();
        repeat (3) step();
        checks++;
        if ({data_a, data_b, mem_rdy, mem_read_en, mem_write_en, err_oob} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got da=%h db=%h rdy=%0b rd=%0b wr=%0b oob=%0b expected all 0",
                     data_a, data_b, mem_rdy, mem_read_en, mem_write_en, err_oob);
        end
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        req_a = 1'b1; addr_a = 16'd0;
        host_we = 1'b1; host_addr = 16'd0; host_wdata = 32'hBAD0BAD0;
        n = 0;
        seen_rd = 1'b0;
        while (mem_rdy !== 1'b1 && n < 100) begin
            n++;
            if (n >= 25) begin req_a = 1'b0; host_we = 1'b0; end
            step();
            if (mem_read_en === 1'b1) seen_rd = 1'b1;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL init_length: got %0d not-ready cycles expected 32", n);
        end
        checks++;
        if (seen_rd !== 1'b0) begin
            failures++;
            $display("FAIL init_ignores_req: got mem_read_en during INIT expected none");
        end
        checks++;
        if (err_oob !== 1'b0) begin
            failures++;
            $display("FAIL init_err: got %0b expected 0", err_oob);
        end
    endtask

    task automatic test_init_zero();
        issue(1, 0, 1, 31, 0, 0, '0, 0, 0, '0);
        checks++;
        if (mem_read_en !== 1'b0 || mem_rdy !== 1'b0) begin
            failures++;
            $display("FAIL zero_t1: got rd=%0b rdy=%0b expected 0 0", mem_read_en, mem_rdy);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b1) begin
            failures++;
            $display("FAIL zero_pulse: got %0b expected 1", mem_read_en);
        end
        sb_pop();
        checks++;
        if (data_a !== held_a || data_b !== held_b) begin
            failures++;
            $display("FAIL zero_data: got a=%h b=%h expected a=%h b=%h", data_a, data_b, held_a, held_b);
        end
        step();
    endtask

    task automatic test_host_read();
        issue(0, 0, 0, 0, 0, 0, '0, 1, 5, 32'hDEADBEEF);
        checks++;
        if (mem_write_en !== 1'b0 || mem_rdy !== 1'b1) begin
            failures++;
            $display("FAIL host_noack: got wr=%0b rdy=%0b expected 0 1", mem_write_en, mem_rdy);
        end
        issue(1, 5, 0, 0, 0, 0, '0, 0, 0, '0);
        checks++;
        if (mem_read_en !== 1'b0 || mem_rdy !== 1'b0) begin
            failures++;
            $display("FAIL hr_t1: got rd=%0b rdy=%0b expected 0 0", mem_read_en, mem_rdy);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b1 || mem_rdy !== 1'b0) begin
            failures++;
            $display("FAIL hr_t2: got rd=%0b rdy=%0b expected 1 0", mem_read_en, mem_rdy);
        end
        sb_pop();
        checks++;
        if (data_a !== held_a) begin
            failures++;
            $display("FAIL hr_data: got %h expected %h", data_a, held_a);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b0 || mem_rdy !== 1'b1 || data_a !== held_a) begin
            failures++;
            $display("FAIL hr_t3: got rd=%0b rdy=%0b a=%h expected 0 1 %h", mem_read_en, mem_rdy, data_a, held_a);
        end
    endtask

    task automatic test_dual_read();
        issue(0, 0, 0, 0, 0, 0, '0, 1, 3, 32'h00000011);
        issue(0, 0, 0, 0, 0, 0, '0, 1, 7, 32'h00000022);
        issue(1, 3, 1, 7, 0, 0, '0, 0, 0, '0);
        step();
        checks++;
        if (mem_read_en !== 1'b1) begin
            failures++;
            $display("FAIL dual_pulse: got %0b expected 1", mem_read_en);
        end
        sb_pop();
        checks++;
        if (data_a !== held_a || data_b !== held_b) begin
            failures++;
            $display("FAIL dual_data: got a=%h b=%h expected a=%h b=%h", data_a, data_b, held_a, held_b);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL dual_single_pulse: got %0b expected 0", mem_read_en);
        end
    endtask

    task automatic test_write_order();
        issue(1, 9, 0, 0, 1, 9, 32'h00001234, 0, 0, '0);
        checks++;
        if (mem_write_en !== 1'b1) begin
            failures++;
            $display("FAIL wo_wen: got %0b expected 1", mem_write_en);
        end
        issue(1, 9, 0, 0, 0, 0, '0, 0, 0, '0);
        checks++;
        if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL wo_t2: got rd=%0b wr=%0b expected 1 0", mem_read_en, mem_write_en);
        end
        sb_pop();
        checks++;
        if (data_a !== held_a) begin
            failures++;
            $display("FAIL wo_old: got %h expected %h", data_a, held_a);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b1) begin
            failures++;
            $display("FAIL wo_pulse2: got %0b expected 1", mem_read_en);
        end
        sb_pop();
        checks++;
        if (data_a !== held_a) begin
            failures++;
            $display("FAIL wo_new: got %h expected %h", data_a, held_a);
        end
        step();
    endtask

    task automatic test_collision();
        issue(0, 0, 0, 0, 1, 12, 32'hC0C00012, 1, 12, 32'hBAD00012);
        checks++;
        if (mem_write_en !== 1'b1) begin
            failures++;
            $display("FAIL col_wen: got %0b expected 1", mem_write_en);
        end
        issue(0, 0, 0, 0, 1, 13, 32'hC0C00013, 1, 14, 32'hB0570014);
        issue(1, 12, 1, 13, 0, 0, '0, 0, 0, '0);
        issue(1, 14, 0, 0, 0, 0, '0, 0, 0, '0);
        sb_pop();
        checks++;
        if (mem_read_en !== 1'b1 || data_a !== held_a || data_b !== held_b) begin
            failures++;
            $display("FAIL col_same_idx: got rd=%0b a=%h b=%h expected 1 %h %h",
                     mem_read_en, data_a, data_b, held_a, held_b);
        end
        step();
        sb_pop();
        checks++;
        if (mem_read_en !== 1'b1 || data_a !== held_a) begin
            failures++;
            $display("FAIL col_diff_idx: got rd=%0b a=%h expected 1 %h", mem_read_en, data_a, held_a);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int aa[4] = '{5, 3, 7, 9};
        int bb[4] = '{9, 7, 3, 5};
        for (int i = 0; i < 4; i++) begin
            issue(1, aa[i], 1, bb[i], 0, 0, '0, 0, 0, '0);
            if (i >= 1) begin
                sb_pop();
                checks++;
                if (mem_read_en !== 1'b1 || mem_rdy !== 1'b0 || data_a !== held_a || data_b !== held_b) begin
                    failures++;
                    $display("FAIL b2b_%0d: got rd=%0b rdy=%0b a=%h b=%h expected 1 0 %h %h",
                             i - 1, mem_read_en, mem_rdy, data_a, data_b, held_a, held_b);
                end
            end
        end
        step();
        sb_pop();
        checks++;
        if (mem_read_en !== 1'b1 || data_a !== held_a || data_b !== held_b) begin
            failures++;
            $display("FAIL b2b_3: got rd=%0b a=%h b=%h expected 1 %h %h",
                     mem_read_en, data_a, data_b, held_a, held_b);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b0 || mem_rdy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain: got rd=%0b rdy=%0b expected 0 1", mem_read_en, mem_rdy);
        end
    endtask

    task automatic test_oob();
        issue(0, 0, 0, 0, 0, 0, '0, 1, 8, 32'h00000088);
        checks++;
        if (err_oob !== 1'b0) begin
            failures++;
            $display("FAIL oob_pre: got %0b expected 0", err_oob);
        end
        issue(0, 0, 0, 0, 1, 40, 32'h0000FFFF, 0, 0, '0);
        checks++;
        if (mem_write_en !== 1'b0 || err_oob !== 1'b1) begin
            failures++;
            $display("FAIL oob_write: got wr=%0b oob=%0b expected 0 1", mem_write_en, err_oob);
        end
        issue(0, 0, 0, 0, 0, 0, '0, 1, 41, 32'h77777777);
        issue(1, 40, 0, 0, 0, 0, '0, 0, 0, '0);
        issue(1, 8, 0, 0, 0, 0, '0, 0, 0, '0);
        sb_pop();
        checks++;
        if (mem_read_en !== 1'b1 || data_a !== held_a) begin
            failures++;
            $display("FAIL oob_read_zero: got rd=%0b a=%h expected 1 %h", mem_read_en, data_a, held_a);
        end
        step();
        sb_pop();
        checks++;
        if (data_a !== held_a) begin
            failures++;
            $display("FAIL oob_no_alias: got %h expected %h", data_a, held_a);
        end
        issue(0, 0, 0, 0, 1, 0, 32'h0000A5A5, 0, 0, '0);
        checks++;
        if (mem_write_en !== 1'b1) begin
            failures++;
            $display("FAIL addr0_wen: got %0b expected 1", mem_write_en);
        end
        issue(0, 0, 1, 0, 0, 0, '0, 0, 0, '0);
        step();
        sb_pop();
        checks++;
        if (data_b !== held_b) begin
            failures++;
            $display("FAIL addr0_data: got %h expected %h", data_b, held_b);
        end
        repeat (5) step();
        checks++;
        if (err_oob !== 1'b1) begin
            failures++;
            $display("FAIL oob_sticky: got %0b expected 1", err_oob);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(1, 5, 0, 0, 0, 0, '0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_oob !== 1'b0 || data_a !== '0 || mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got oob=%0b a=%h rd=%0b expected 0 0 0", err_oob, data_a, mem_read_en);
        end
        step();
        checks++;
        if (mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_discard: got %0b expected 0", mem_read_en);
        end
        clear_model();
        rst_n = 1'b1;
        n = 0;
        while (mem_rdy !== 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL rst_mid_sweep: got %0d not-ready cycles expected 32", n);
        end
        issue(1, 5, 1, 12, 0, 0, '0, 0, 0, '0);
        step();
        sb_pop();
        checks++;
        if (mem_read_en !== 1'b1 || data_a !== held_a || data_b !== held_b) begin
            failures++;
            $display("FAIL rst_mid_cleared: got rd=%0b a=%h b=%h expected 1 %h %h",
                     mem_read_en, data_a, data_b, held_a, held_b);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_host_read();
        test_dual_read();
        test_write_order();
        test_collision();
        test_back_to_back();
        test_oob();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
